sign_bit_merger: RTL and testbench

SIGN_BIT_MERGER -- requirements
Module: sign_bit_merger

---
 rtl/sign_bit_merger.sv | 99 +++++++++
 tb/tb_sign_bit_merger.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sign_bit_merger.sv
// Merges per-segment sign-flip descriptors into a bitstream: inverts the final bit of each flagged segment.
// Optional flipped-bit statistics counter (flip_count) enabled by defining SIGN_MERGER_STAT_EN.
module sign_bit_merger #(
  parameter int unsigned STAT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] count_in,
  input  logic       count_in_empty,
  output logic       count_in_rd,
  input  logic       bit_in,
  input  logic       bit_in_empty,
  output logic       bit_in_rd,
  input  logic       bit_out_afull,
  output logic       bit_out,
  output logic       bit_out_wr
`ifdef SIGN_MERGER_STAT_EN
  ,
  output logic [STAT_W-1:0] flip_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e     state_q, state_d;
  logic [6:0] rem_q, rem_d;
  logic       flip_q, flip_d;
  logic       bv_q, bv_d;
  logic       bo_q, bo_d;
  logic       wr_q;
  logic       fire, last;

  assign last        = (rem_q == 7'd1);
  assign fire        = (state_q == RUN) && bv_q && !bit_out_afull && clk_en;
  assign bit_in_rd   = clk_en && (state_q == RUN) && (!bv_q || fire);
  assign count_in_rd = clk_en && (state_q == IDLE);
  assign bit_out     = bo_q;
  assign bit_out_wr  = wr_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    flip_d  = flip_q;
    bo_d    = bo_q;
    bv_d    = bv_q;
    unique case (state_q)
      IDLE: if (clk_en && !count_in_empty) state_d = LOAD;
      LOAD: if (clk_en) begin
        rem_d   = count_in[6:0];
        flip_d  = count_in[7];
        state_d = (count_in[6:0] != 7'd0) ? RUN : IDLE;
      end
      RUN: if (fire) begin
        rem_d = rem_q - 7'd1;
        bo_d  = bit_in ^ (flip_q && last);
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The FIFO holds its output until the next read, so bit_in stays valid while bv_q is set.
    if (bit_in_rd && !bit_in_empty) bv_d = 1'b1;
    else if (fire)                  bv_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      flip_q  <= 1'b0;
      bv_q    <= 1'b0;
      bo_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      flip_q  <= flip_d;
      bv_q    <= bv_d;
      bo_q    <= bo_d;
      wr_q    <= fire;
    end
  end

`ifdef SIGN_MERGER_STAT_EN
  logic [STAT_W-1:0] fc_q;
  logic              flip_hit;

  assign flip_hit   = fire && flip_q && last;
  assign flip_count = fc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      fc_q <= '0;
    else if (flip_hit && fc_q != '1) fc_q <= fc_q + 1'b1;
  end
`else
  // Statistics disabled: no flip_count port or counter.
`endif

endmodule

// File: tb/tb_sign_bit_merger.sv
// Directed bench for sign_bit_merger: behavioural FIFO models around the DUT, vector table plus corner sequences.
module tb_sign_bit_merger;
  localparam int unsigned TB_STAT_W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b1;
  logic [7:0] count_in = 8'h00;
  logic       count_in_empty = 1'b1;
  logic       count_in_rd;
  logic       bit_in = 1'b0;
  logic       bit_in_empty = 1'b1;
  logic       bit_in_rd;
  logic       bit_out_afull = 1'b0;
  logic       bit_out;
  logic       bit_out_wr;
`ifdef SIGN_MERGER_STAT_EN
  logic [TB_STAT_W-1:0] flip_count;
`endif

  sign_bit_merger #(.STAT_W(TB_STAT_W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .count_in(count_in), .count_in_empty(count_in_empty), .count_in_rd(count_in_rd),
    .bit_in(bit_in), .bit_in_empty(bit_in_empty), .bit_in_rd(bit_in_rd),
    .bit_out_afull(bit_out_afull), .bit_out(bit_out), .bit_out_wr(bit_out_wr)
`ifdef SIGN_MERGER_STAT_EN
    , .flip_count(flip_count)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] cq[$];
  logic       bq[$];
  logic       outq[$];
  int         wcyc[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: FIFO models pop on strobes seen before the edge; outputs logged #1 after it.
  task automatic tick();
    logic crd, brd;
    count_in_empty = (cq.size() == 0);
    bit_in_empty   = (bq.size() == 0);
    crd = count_in_rd;
    brd = bit_in_rd;
    @(posedge clk);
    #1;
    cyc++;
    if (crd && cq.size() > 0) count_in = cq.pop_front();
    if (brd && bq.size() > 0) bit_in = bq.pop_front();
    count_in_empty = (cq.size() == 0);
    bit_in_empty   = (bq.size() == 0);
    if (bit_out_wr) begin
      outq.push_back(bit_out);
      wcyc.push_back(cyc);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int n, input int budget);
    int b;
    b = 0;
    while (outq.size() < n && b < budget) begin
      tick();
      b++;
    end
  endtask

  task automatic clear_log();
    outq.delete();
    wcyc.delete();
  endtask

  typedef struct {
    string      name;
    logic [7:0] d0, d1;
    int         nd;
    logic [7:0] bits;
    int         nb;
    logic [7:0] exp;
    int         ne;
    int         gap_at;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [7:0] ob;
    int         errs;
    logic       e;

    vt[0] = '{"flip3",      8'h83, 8'h00, 1, 8'b00101, 3, 8'b00001, 3, -1};
    vt[1] = '{"two_seg",    8'h03, 8'h82, 2, 8'b00111, 5, 8'b10111, 5,  3};
    vt[2] = '{"zero_drop",  8'h80, 8'h01, 2, 8'b00001, 1, 8'b00001, 1, -1};
    vt[3] = '{"len1_flip",  8'h81, 8'h00, 1, 8'b00000, 1, 8'b00001, 1, -1};
    vt[4] = '{"len4_flip",  8'h84, 8'h00, 1, 8'b00000, 4, 8'b01000, 4, -1};
    vt[5] = '{"two_seg_b",  8'h02, 8'h81, 2, 8'b00101, 3, 8'b00001, 3,  2};
    vt[6] = '{"len1_plain", 8'h01, 8'h00, 1, 8'b00000, 1, 8'b00000, 1, -1};

    // Reset state
    ticks(2);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_wr", bit_out_wr, 0);
    chk("rst_bit_rd", bit_in_rd, 0);
    chk("rst_cnt_rd_idle", count_in_rd, 1);
    rst = 1'b1;
    ticks(2);

    foreach (vt[v]) begin
      clear_log();
      cq.push_back(vt[v].d0);
      if (vt[v].nd > 1) cq.push_back(vt[v].d1);
      for (int i = 0; i < vt[v].nb; i++) bq.push_back(vt[v].bits[i]);
      run_until(vt[v].ne, 300);
      ticks(10);
      chk({vt[v].name, "_count"}, outq.size(), vt[v].ne);
      ob = '0;
      for (int i = 0; i < outq.size() && i < 8; i++) ob[i] = outq[i];
      chk({vt[v].name, "_data"}, ob, vt[v].exp);
      if (vt[v].gap_at > 0 && wcyc.size() > vt[v].gap_at)
        chk({vt[v].name, "_gap"}, wcyc[vt[v].gap_at] - wcyc[vt[v].gap_at-1], 3);
      chk({vt[v].name, "_bits_left"}, bq.size(), 0);
      chk({vt[v].name, "_idle"}, count_in_rd, 1);
    end

    // 127-bit segment with a 5-cycle afull pulse mid-run
    clear_log();
    cq.push_back(8'hFF);
    for (int i = 0; i < 127; i++) bq.push_back(i % 3 == 0);
    ticks(40);
    bit_out_afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("afull_wr", bit_out_wr, 0);
    end
    bit_out_afull = 1'b0;
    run_until(127, 400);
    ticks(10);
    chk("max_count", outq.size(), 127);
    errs = 0;
    for (int i = 0; i < outq.size() && i < 127; i++) begin
      e = (i % 3 == 0) ^ (i == 126);
      if (outq[i] !== e) errs++;
    end
    chk("max_data_errs", errs, 0);

    // Bit FIFO runs dry mid-segment, then clk_en dropped
    clear_log();
    cq.push_back(8'h86);
    bq.push_back(1'b1); bq.push_back(1'b1); bq.push_back(1'b0);
    ticks(15);
    chk("stall_count", outq.size(), 3);
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clken_wr", bit_out_wr, 0);
      chk("clken_rd", {count_in_rd, bit_in_rd}, 0);
    end
    chk("clken_hold_count", outq.size(), 3);
    clk_en = 1'b1;
    run_until(6, 100);
    ticks(5);
    chk("stall_total", outq.size(), 6);
    ob = '0;
    for (int i = 0; i < outq.size() && i < 8; i++) ob[i] = outq[i];
    chk("stall_data", ob, 8'b001011);

    // Reset mid-segment
    clear_log();
    cq.push_back(8'h8A);
    for (int i = 0; i < 10; i++) bq.push_back(1'b1);
    ticks(6);
    rst = 1'b0;
    #1;
    chk("midrst_bit_out", bit_out, 0);
    chk("midrst_wr", bit_out_wr, 0);
    tick();
    rst = 1'b1;
    bq.delete();
    cq.delete();
    clear_log();
    ticks(2);
    chk("postrst_idle", count_in_rd, 1);
    cq.push_back(8'h83);
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1);
    run_until(3, 100);
    ticks(8);
    chk("postrst_count", outq.size(), 3);
    ob = '0;
    for (int i = 0; i < outq.size() && i < 8; i++) ob[i] = outq[i];
    chk("postrst_data", ob, 8'b001);

`ifdef SIGN_MERGER_STAT_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clear_log();
    chk("stat_reset", flip_count, 0);
    for (int i = 0; i < 20; i++) begin
      cq.push_back(8'h81);
      bq.push_back(1'b0);
    end
    run_until(5, 200);
    chk("stat_mid", flip_count, 5);
    run_until(20, 400);
    ticks(5);
    chk("stat_writes", outq.size(), 20);
    chk("stat_sat", flip_count, 4'hF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
